// File: rtl/npu_cnt_pkg.sv
// npu_cnt_pkg: shared state encoding, compressor count-word weights and weighted decode helper
package npu_cnt_pkg;
    typedef enum logic {ACCUM, HOLD} cnt_state_t;
    localparam int W_SUM   = 1;
    localparam int W_CARRY = 2;
    localparam int W_COUT  = 4;
    function automatic logic [2:0] cnt_value(input logic cout, input logic carry, input logic sum);
        return 3'(W_COUT * int'(cout) + W_CARRY * int'(carry) + W_SUM * int'(sum));
    endfunction
endpackage

// File: rtl/cnt_word_decode.sv
// cnt_word_decode: combinational weighted decode of a {cout, carry, sum} count word
//   cout, carry, sum : compressor output bits (weights 4, 2, 1)
//   value            : 3-bit binary value 0..7
module cnt_word_decode
    import npu_cnt_pkg::*;
(
    input  logic       cout,
    input  logic       carry,
    input  logic       sum,
    output logic [2:0] value
);
    assign value = cnt_value(cout, carry, sum);
endmodule

// File: rtl/popcount_accumulator.sv
// popcount_accumulator: sums a frame of up to BEATS compressor count words into one registered total
//   clk, reset                  : clock, async active-high reset
//   in_valid/in_ready           : input handshake, word = {in_cout, in_carry, in_sum}
//   in_last                     : closes the frame early
//   out_valid/out_ready         : output handshake
//   out_total, out_beats        : frame total and number of words in the frame
module popcount_accumulator
    import npu_cnt_pkg::*;
#(
    parameter int BEATS = 8,
    parameter int ACC_W = 6,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_cout,
    input  logic             in_carry,
    input  logic             in_sum,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [CNT_W-1:0] out_beats
);
    cnt_state_t       state, state_nxt;
    logic             armed;
    logic [2:0]       v;
    logic [ACC_W-1:0] acc, acc_sum;
    logic [CNT_W-1:0] beat_cnt;
    logic             accept, final_beat;

    cnt_word_decode u_dec (
        .cout  (in_cout),
        .carry (in_carry),
        .sum   (in_sum),
        .value (v)
    );

    // armed keeps in_ready low while reset is held and until the first clock after release
    assign in_ready   = armed && state == ACCUM;
    assign out_valid  = state == HOLD;
    assign accept     = in_valid && in_ready;
    assign final_beat = in_last || beat_cnt == CNT_W'(BEATS - 1);
    assign acc_sum    = acc + ACC_W'(v);

    always_comb begin
        state_nxt = state;
        state_nxt = (state == ACCUM) ? ((accept && final_beat) ? HOLD : ACCUM)
                                     : (out_ready ? ACCUM : HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACCUM;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            beat_cnt  <= '0;
            out_total <= '0;
            out_beats <= '0;
        end else if (accept) begin
            if (final_beat) begin
                out_total <= acc_sum;
                out_beats <= beat_cnt + CNT_W'(1);
                acc       <= '0;
                beat_cnt  <= '0;
            end else begin
                acc      <= acc_sum;
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_popcount_accumulator.sv
// tb_popcount_accumulator: directed self-checking bench for popcount_accumulator
module tb_popcount_accumulator;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0, in_cout = 1'b0, in_carry = 1'b0, in_sum = 1'b0, in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid;
    logic [5:0] out_total;
    logic [3:0] out_beats;
    int         tests = 0;
    int         fails = 0;

    popcount_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cout   (in_cout),
        .in_carry  (in_carry),
        .in_sum    (in_sum),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_total (out_total),
        .out_beats (out_beats)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] v, input logic last);
        int n = 0;
        {in_cout, in_carry, in_sum} = v;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick;
            n++;
        end
        if (!in_ready) check("send_ready_timeout", int'(in_ready), 1);
        tick;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take(input string tag, input int tot, input int bts);
        int n = 0;
        while (!out_valid && n < 50) begin
            tick;
            n++;
        end
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_total"}, int'(out_total), tot);
        check({tag, "_beats"}, int'(out_beats), bts);
        check({tag, "_hold_ready"}, int'(in_ready), 0);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({tag, "_release_valid"}, int'(out_valid), 0);
        check({tag, "_release_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        #2;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_total", int'(out_total), 0);
        check("rst_beats", int'(out_beats), 0);
        #10 reset = 1'b0;
        check("rst_released_ready_low", int'(in_ready), 0);
        tick;
        check("post_rst_ready", int'(in_ready), 1);

        for (int i = 0; i < 7; i++) send(3'd6, 1'b0);
        check("full_not_yet_valid", int'(out_valid), 0);
        send(3'd6, 1'b0);
        check("full_latency_valid", int'(out_valid), 1);
        take("full", 48, 8);

        send(3'd5, 1'b0);
        send(3'd3, 1'b0);
        send(3'd7, 1'b1);
        take("early", 15, 3);
        send(3'd1, 1'b1);
        take("first_last", 1, 1);

        send(3'd3, 1'b1);
        {in_cout, in_carry, in_sum} = 3'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_total", int'(out_total), 3);
            check("bp_valid", int'(out_valid), 1);
            check("bp_ready", int'(in_ready), 0);
            tick;
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("bp_ready_back", int'(in_ready), 1);
        tick;
        in_valid = 1'b0;
        send(3'd1, 1'b1);
        take("bp_pending", 3, 2);

        for (int i = 0; i < 8; i++) begin
            send(3'd1, 1'b0);
            in_last = 1'b1;
            tick;
            in_last = 1'b0;
        end
        take("bubbles", 8, 8);

        for (int i = 0; i < 3; i++) send(3'd4, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_ready", int'(in_ready), 0);
        check("midrst_total", int'(out_total), 0);
        #2 reset = 1'b0;
        tick;
        check("midrst_ready_back", int'(in_ready), 1);
        for (int i = 0; i < 8; i++) send(3'd1, 1'b0);
        take("after_rst", 8, 8);

        for (int i = 0; i < 8; i++) send(3'd7, 1'b0);
        take("max", 56, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
